// File: rtl/ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, register-address width, x0.
package ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned STATE_W    = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN     = 2'd1;
    localparam logic [STATE_W-1:0] ST_MEMWAIT = 2'd2;
    localparam logic [STATE_W-1:0] ST_TIMEOUT = 2'd3;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory waits
// with timeout, plus saturating stall/flush performance counters.
module hazard_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  IDEX_MemRead_i,
    input  logic [REG_ADDR_W-1:0] IDEX_Rd_i,
    input  logic [REG_ADDR_W-1:0] IFID_Rs1_i,
    input  logic [REG_ADDR_W-1:0] IFID_Rs2_i,
    input  logic                  Branch_taken_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    output logic                  PCWrite_o,
    output logic                  IFID_Stall_o,
    output logic                  IFID_Flush_o,
    output logic                  IDEX_Bubble_o,
    output logic                  Pipe_Freeze_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic                  timeout_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic                timeout_q;
    logic                stall_inc;
    logic                flush_inc;
    logic                memstall;
    logic                luh;

    assign memstall = mem_req_i & ~mem_ack_i;
    assign luh      = IDEX_MemRead_i & (IDEX_Rd_i != X0) &
                      ((IDEX_Rd_i == IFID_Rs1_i) | (IDEX_Rd_i == IFID_Rs2_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state_nxt == ST_TIMEOUT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Mealy control: start_i low overrides every state with the IDLE outputs.
    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        PCWrite_o     = 1'b0;
        IFID_Stall_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        Pipe_Freeze_o = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (!start_i) begin
            IFID_Flush_o = 1'b1;
            state_nxt    = ST_IDLE;
            wait_nxt     = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    IFID_Flush_o = 1'b1;
                    state_nxt    = ST_RUN;
                end
                ST_RUN: begin
                    if (memstall) begin
                        IFID_Stall_o  = 1'b1;
                        Pipe_Freeze_o = 1'b1;
                        stall_inc     = 1'b1;
                        state_nxt     = ST_MEMWAIT;
                        wait_nxt      = WAIT_W'(1);
                    end else if (luh) begin
                        IFID_Stall_o  = 1'b1;
                        IDEX_Bubble_o = 1'b1;
                        stall_inc     = 1'b1;
                    end else if (Branch_taken_i) begin
                        PCWrite_o    = 1'b1;
                        IFID_Flush_o = 1'b1;
                        flush_inc    = 1'b1;
                    end else begin
                        PCWrite_o = 1'b1;
                    end
                end
                ST_MEMWAIT: begin
                    IFID_Stall_o  = 1'b1;
                    Pipe_Freeze_o = 1'b1;
                    stall_inc     = 1'b1;
                    if (mem_ack_i) begin
                        state_nxt = ST_RUN;
                        wait_nxt  = '0;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                        state_nxt = ST_TIMEOUT;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end
                ST_TIMEOUT: begin
                    IFID_Stall_o  = 1'b1;
                    Pipe_Freeze_o = 1'b1;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    wait_nxt  = '0;
                end
            endcase
        end
    end

    assign timeout_o = timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a short timeout and narrow counters.
module tb_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;

    // Control vector order: {PCWrite, IFID_Stall, IFID_Flush, IDEX_Bubble, Pipe_Freeze}
    localparam logic [4:0] C_IDLE = 5'b00100;
    localparam logic [4:0] C_RUN  = 5'b10000;
    localparam logic [4:0] C_LUH  = 5'b01010;
    localparam logic [4:0] C_BR   = 5'b10100;
    localparam logic [4:0] C_FRZ  = 5'b01001;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             memread;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             br;
    logic             req;
    logic             ack;
    logic             pcwrite;
    logic             stall;
    logic             flush;
    logic             bubble;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .IDEX_MemRead_i (memread),
        .IDEX_Rd_i      (rd),
        .IFID_Rs1_i     (rs1),
        .IFID_Rs2_i     (rs2),
        .Branch_taken_i (br),
        .mem_req_i      (req),
        .mem_ack_i      (ack),
        .PCWrite_o      (pcwrite),
        .IFID_Stall_o   (stall),
        .IFID_Flush_o   (flush),
        .IDEX_Bubble_o  (bubble),
        .Pipe_Freeze_o  (freeze),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .timeout_o      (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, 32'({pcwrite, stall, flush, bubble, freeze}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        memread = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
        br = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_in();
        #3;
        chk_ctl("reset_ctl", C_IDLE);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        #1 chk_ctl("idle_start_ctl", C_IDLE);
        tick();
        #1 chk_ctl("run_idle_ctl", C_RUN);

        // load-use via rs2, branch ignored
        memread = 1'b1; rd = 5'd5; rs2 = 5'd5; br = 1'b1;
        #1 chk_ctl("luh_rs2_ctl", C_LUH);
        tick();
        chk("luh_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("luh_flush_cnt", 32'(flush_cnt), 32'd0);

        // x0 destination never stalls
        rd = 5'd0; rs2 = 5'd0; br = 1'b0;
        #1 chk_ctl("luh_x0_ctl", C_RUN);
        tick();
        chk("luh_x0_stall_cnt", 32'(stall_cnt), 32'd1);

        rd = 5'd7; rs1 = 5'd7;
        #1 chk_ctl("luh_rs1_ctl", C_LUH);
        tick();
        chk("luh_rs1_stall_cnt", 32'(stall_cnt), 32'd2);

        memread = 1'b0;
        #1 chk_ctl("no_load_ctl", C_RUN);
        tick();
        clear_in();

        br = 1'b1;
        #1 chk_ctl("branch_ctl", C_BR);
        tick();
        br = 1'b0;
        #1 chk("branch_flush_cnt", 32'(flush_cnt), 32'd1);
        chk_ctl("after_branch_ctl", C_RUN);

        // memory wait: three unacked cycles then ack; luh/branch present but ignored
        req = 1'b1; memread = 1'b1; rd = 5'd5; rs2 = 5'd5; br = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk_ctl("memwait_ctl", C_FRZ);
            tick();
        end
        ack = 1'b1;
        #1 chk_ctl("memwait_ack_ctl", C_FRZ);
        tick();
        clear_in();
        #1 chk_ctl("after_ack_ctl", C_RUN);
        chk("memwait_stall_cnt", 32'(stall_cnt), 32'd6);
        chk("memwait_flush_cnt", 32'(flush_cnt), 32'd1);

        req = 1'b1; ack = 1'b1;
        #1 chk_ctl("req_ack_same_ctl", C_RUN);
        tick();
        clear_in();
        #1 chk_ctl("req_ack_next_ctl", C_RUN);
        chk("req_ack_stall_cnt", 32'(stall_cnt), 32'd6);

        // start_i low aborts a wait immediately
        req = 1'b1;
        #1 chk_ctl("abort_enter_ctl", C_FRZ);
        tick();
        start = 1'b0;
        #1 chk_ctl("abort_same_cycle_ctl", C_IDLE);
        tick();
        req = 1'b0;
        #1 chk_ctl("abort_idle_ctl", C_IDLE);
        start = 1'b1;
        #1 chk_ctl("abort_restart_ctl", C_IDLE);
        tick();
        #1 chk_ctl("abort_run_ctl", C_RUN);

        // timeout: RUN stall cycle + TIMEOUT MEMWAIT cycles, then TIMEOUT
        req = 1'b1;
        #1 chk_ctl("to_enter_ctl", C_FRZ);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1 chk_ctl("to_wait_ctl", C_FRZ);
            chk("to_wait_flag", 32'(timeout), 32'd0);
            tick();
        end
        #1 chk_ctl("to_state_ctl", C_FRZ);
        chk("to_flag_set", 32'(timeout), 32'd1);
        req = 1'b0;
        tick();
        #1 chk_ctl("to_hold_ctl", C_FRZ);
        chk("to_flag_hold", 32'(timeout), 32'd1);
        start = 1'b0;
        #1 chk_ctl("to_exit_ctl", C_IDLE);
        tick();
        chk("to_flag_idle", 32'(timeout), 32'd1);
        start = 1'b1;
        tick();
        #1 chk_ctl("to_rerun_ctl", C_RUN);
        chk("to_flag_rerun", 32'(timeout), 32'd1);

        // flush counter saturates at 2^CNT_W-1
        br = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        #1 chk_ctl("sat_branch_ctl", C_BR);
        br = 1'b0;
        chk("sat_flush_cnt", 32'(flush_cnt), 32'd15);

        // async reset mid-wait
        req = 1'b1;
        tick();
        #1 chk_ctl("rst_pre_ctl", C_FRZ);
        #2 rst = 1'b1;
        #1 chk_ctl("rst_async_ctl", C_IDLE);
        chk("rst_async_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_async_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_async_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        #1 chk_ctl("rst_release_ctl", C_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline-control unit for the 5-stage RISC-V core.
- Drives PC write-enable, IF/ID stall and flush, ID/EX bubble, and a whole-pipe freeze.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits (req/ack handshake) in a small FSM.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
- TIMEOUT, 256, max MEMWAIT cycles before entering TIMEOUT (≥2).
- CNT_W, 16, width of performance counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  core run enable; low forces IDLE.
- IDEX_MemRead_i  in  1  instruction in EX is a load.
- IDEX_Rd_i  in  5  destination register of the EX instruction.
- IFID_Rs1_i  in  5  rs1 of the ID instruction.
- IFID_Rs2_i  in  5  rs2 of the ID instruction.
- Branch_taken_i  in  1  branch in ID resolved taken.
- mem_req_i  in  1  MEM stage has an outstanding data access.
- mem_ack_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFID_Stall_o  out  1  hold IF/ID.
- IFID_Flush_o  out  1  zero IF/ID.
- IDEX_Bubble_o  out  1  insert NOP into ID/EX.
- Pipe_Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0 while in RUN or MEMWAIT; saturating.
- flush_cnt_o  out  CNT_W  cycles with IFID_Flush_o=1 while in RUN; saturating.
- timeout_o  out  1  sticky memory-timeout flag.

Behaviour:
- FSM states: IDLE, RUN, MEMWAIT, TIMEOUT.
- Reset: state=IDLE; wait counter, stall_cnt_o, flush_cnt_o and timeout_o = 0.
- Outputs are combinational from state and inputs (Mealy); no added latency.
- Signal definitions:
  - memstall = mem_req_i & ~mem_ack_i.
  - luh = IDEX_MemRead_i & (IDEX_Rd_i≠0) & (IDEX_Rd_i==IFID_Rs1_i | IDEX_Rd_i==IFID_Rs2_i).
- IDLE outputs: PCWrite_o=0, IFID_Flush_o=1, all other controls 0.
- IDLE transition: start_i=1 → RUN next cycle.
- RUN, priority memstall > luh > branch:
  - memstall: PCWrite_o=0, IFID_Stall_o=1, Pipe_Freeze_o=1, Bubble=0, Flush=0; next state MEMWAIT, wait counter loads 1.
  - else luh: PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, Flush=0. Branch_taken_i is ignored; the branch re-resolves next cycle.
  - else Branch_taken_i: IFID_Flush_o=1, PCWrite_o=1.
  - else: PCWrite_o=1, all other controls 0.
- MEMWAIT outputs: same as RUN-memstall; luh and branch are ignored.
  - mem_ack_i=1 → freeze still asserted this cycle, RUN next.
  - else wait counter increments; on reaching TIMEOUT → TIMEOUT next.
- TIMEOUT outputs: timeout_o=1 (sticky until rst_i), PCWrite_o=0, IFID_Stall_o=1, Pipe_Freeze_o=1.
  - Exits only via reset or start_i=0.
- start_i=0 in any state:
  - Next state is IDLE; aborts MEMWAIT mid-wait.
  - Wait counter clears; perf counters and timeout_o hold.
  - Outputs in that same cycle are already the IDLE outputs.
- Counters saturate at 2^CNT_W−1 with no wrap.
- Simultaneous mem_req_i & mem_ack_i in RUN: no stall at all.
- rst_i asserted mid-MEMWAIT: immediate async return to IDLE; all outputs take their IDLE values.

Decomposition:
- Shared package ctrl_pkg holds:
  - the state enum (IDLE/RUN/MEMWAIT/TIMEOUT);
  - REG_ADDR_W=5;
  - the x0 constant.
- One natural sub-module, sat_counter (CNT_W, inc, clear), instantiated twice for the perf counters.

Test Plan:
- Reset then start_i=1 → IDLE outputs (Flush=1, PCWrite=0) for one cycle, then RUN with PCWrite_o=1 and all controls 0.
- Load-use: IDEX_MemRead_i=1, IDEX_Rd_i=5, IFID_Rs2_i=5, Branch_taken_i=1 → PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, IFID_Flush_o=0 for 1 cycle; stall_cnt_o increments by 1. Same stimulus with Rd=0 → no stall.
- Branch only → IFID_Flush_o=1 for 1 cycle; flush_cnt_o=1.
- mem_req_i held with mem_ack_i low for 3 cycles, ack on the 4th → Pipe_Freeze_o=1 for 4 cycles, then RUN; stall_cnt_o=4.
- TIMEOUT=4, ack never arrives → TIMEOUT state entered after the 4th MEMWAIT cycle; timeout_o=1 sticky; start_i=0 → IDLE with timeout_o still 1.
- Async rst_i pulse between clock edges mid-MEMWAIT → outputs immediately take IDLE values; counters and timeout_o read 0.
